// File: rtl/vreg_access_ctrl.sv
// Round-robin sequencer for the vector register file: grants one whole-vector
// read or write burst at a time to requester A or B and drives the file's ports.
module vreg_access_ctrl #(
    parameter  int VLEN = 16,
    parameter  int AW   = 3,
    localparam int EW   = $clog2(VLEN)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          ReqA,
    input  logic          OpA,
    input  logic [AW-1:0] SrcA1,
    input  logic [AW-1:0] SrcA2,
    input  logic [AW-1:0] DstA,
    input  logic          ReqB,
    input  logic          OpB,
    input  logic [AW-1:0] SrcB1,
    input  logic [AW-1:0] SrcB2,
    input  logic [AW-1:0] DstB,
    output logic          GntA,
    output logic          GntB,
    output logic          DoneA,
    output logic          DoneB,
    output logic          Owner,
    output logic          Busy,
    output logic [EW-1:0] Elem,
    output logic          Last,
    output logic [AW-1:0] Addr,
    output logic [AW-1:0] Addr2,
    output logic [AW-1:0] AddrW,
    output logic          RD_s,
    output logic          WR_s
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        BURST,
        DONE
    } state_t;

    localparam logic [EW-1:0] ELEM_MAX = EW'(VLEN - 1);

    state_t        state;
    logic          op_q;
    logic          prefer_b;
    logic          grant_any;
    logic          grant_b;
    logic [EW-1:0] elem_next;

    // B wins only when A is absent or A was the one served last.
    always_comb begin
        grant_any = ReqA | ReqB;
        grant_b   = ReqB & (~ReqA | prefer_b);
        elem_next = Elem + EW'(1);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            prefer_b <= 1'b0;
            GntA     <= 1'b0;
            GntB     <= 1'b0;
            DoneA    <= 1'b0;
            DoneB    <= 1'b0;
            Owner    <= 1'b0;
            Busy     <= 1'b0;
            Elem     <= '0;
            Last     <= 1'b0;
            Addr     <= '0;
            Addr2    <= '0;
            AddrW    <= '0;
            RD_s     <= 1'b0;
            WR_s     <= 1'b0;
        end else begin
            GntA  <= 1'b0;
            GntB  <= 1'b0;
            DoneA <= 1'b0;
            DoneB <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= SETUP;
                        Busy  <= 1'b1;
                        Owner <= grant_b;
                        GntA  <= ~grant_b;
                        GntB  <= grant_b;
                        op_q  <= grant_b ? OpB   : OpA;
                        Addr  <= grant_b ? SrcB1 : SrcA1;
                        Addr2 <= grant_b ? SrcB2 : SrcA2;
                        AddrW <= grant_b ? DstB  : DstA;
                    end
                end
                // Addresses settle for one cycle before the first strobe.
                SETUP: begin
                    state <= BURST;
                    RD_s  <= ~op_q;
                    WR_s  <= op_q;
                    Elem  <= '0;
                    Last  <= (ELEM_MAX == '0);
                end
                BURST: begin
                    if (Elem == ELEM_MAX) begin
                        state <= DONE;
                        RD_s  <= 1'b0;
                        WR_s  <= 1'b0;
                        Elem  <= '0;
                        Last  <= 1'b0;
                        DoneA <= ~Owner;
                        DoneB <= Owner;
                    end else begin
                        Elem <= elem_next;
                        Last <= (elem_next == ELEM_MAX);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    Busy     <= 1'b0;
                    prefer_b <= ~Owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vreg_access_ctrl.sv
// Randomized bench for vreg_access_ctrl against a transaction-timeline model
// (cycles elapsed since grant) including random asynchronous resets mid-burst.
module tb_vreg_access_ctrl;

    localparam int VLEN   = 16;
    localparam int AW     = 3;
    localparam int EW     = $clog2(VLEN);
    localparam int CYCLES = 3000;

    logic          Clk;
    logic          Rst_n;
    logic          ReqA, OpA, ReqB, OpB;
    logic [AW-1:0] SrcA1, SrcA2, DstA, SrcB1, SrcB2, DstB;
    logic          GntA, GntB, DoneA, DoneB, Owner, Busy, Last, RD_s, WR_s;
    logic [EW-1:0] Elem;
    logic [AW-1:0] Addr, Addr2, AddrW;

    int test_count = 0;
    int fail_count = 0;

    // Model: a burst is a timeline of VLEN+2 cycles counted from the grant cycle.
    bit          m_busy;
    int          m_t;
    bit          m_owner;
    bit          m_op;
    bit          m_prefer_b;
    logic [AW-1:0] m_addr, m_addr2, m_addrw;
    int          grants_seen = 0;

    vreg_access_ctrl #(.VLEN(VLEN), .AW(AW)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqA(ReqA), .OpA(OpA), .SrcA1(SrcA1), .SrcA2(SrcA2), .DstA(DstA),
        .ReqB(ReqB), .OpB(OpB), .SrcB1(SrcB1), .SrcB2(SrcB2), .DstB(DstB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .Owner(Owner), .Busy(Busy), .Elem(Elem), .Last(Last),
        .Addr(Addr), .Addr2(Addr2), .AddrW(AddrW), .RD_s(RD_s), .WR_s(WR_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus();
        ReqA  = ($urandom_range(3) != 0);
        ReqB  = ($urandom_range(3) != 0);
        OpA   = 1'($urandom_range(1));
        OpB   = 1'($urandom_range(1));
        SrcA1 = 3'($urandom_range(7));
        SrcA2 = 3'($urandom_range(7));
        DstA  = 3'($urandom_range(7));
        SrcB1 = 3'($urandom_range(7));
        SrcB2 = 3'($urandom_range(7));
        DstB  = 3'($urandom_range(7));
    endtask

    task automatic modelReset();
        m_busy     = 1'b0;
        m_t        = 0;
        m_owner    = 1'b0;
        m_op       = 1'b0;
        m_prefer_b = 1'b0;
        m_addr     = '0;
        m_addr2    = '0;
        m_addrw    = '0;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic modelStep();
        bit pick_b;
        if (!Rst_n) begin
            modelReset();
        end else if (m_busy) begin
            if (m_t == VLEN + 1) begin
                m_busy     = 1'b0;
                m_prefer_b = !m_owner;
            end else begin
                m_t++;
            end
        end else if (ReqA || ReqB) begin
            if (ReqA && ReqB) pick_b = m_prefer_b;
            else              pick_b = ReqB;
            m_busy  = 1'b1;
            m_t     = 0;
            m_owner = pick_b;
            m_op    = pick_b ? OpB : OpA;
            m_addr  = pick_b ? SrcB1 : SrcA1;
            m_addr2 = pick_b ? SrcB2 : SrcA2;
            m_addrw = pick_b ? DstB : DstA;
            grants_seen++;
        end
    endtask

    task automatic checkAll();
        bit active;
        active = m_busy && (m_t >= 1) && (m_t <= VLEN);
        checkOutput("GntA",  GntA,  m_busy && m_t == 0 && !m_owner);
        checkOutput("GntB",  GntB,  m_busy && m_t == 0 && m_owner);
        checkOutput("DoneA", DoneA, m_busy && m_t == VLEN + 1 && !m_owner);
        checkOutput("DoneB", DoneB, m_busy && m_t == VLEN + 1 && m_owner);
        checkOutput("Busy",  Busy,  m_busy);
        if (m_busy) checkOutput("Owner", Owner, m_owner);
        checkOutput("RD_s",  RD_s,  active && !m_op);
        checkOutput("WR_s",  WR_s,  active && m_op);
        checkOutput("Elem",  Elem,  active ? m_t - 1 : 0);
        checkOutput("Last",  Last,  active && m_t == VLEN);
        checkOutput("Addr",  Addr,  m_addr);
        checkOutput("Addr2", Addr2, m_addr2);
        checkOutput("AddrW", AddrW, m_addrw);
    endtask

    initial begin
        Rst_n = 1'b0;
        ReqA = 0; ReqB = 0; OpA = 0; OpB = 0;
        SrcA1 = '0; SrcA2 = '0; DstA = '0; SrcB1 = '0; SrcB2 = '0; DstB = '0;
        modelReset();
        repeat (2) @(posedge Clk);
        #1 checkAll();
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            applyStimulus();
            if (m_busy && m_t >= 1 && m_t <= VLEN && $urandom_range(39) == 0) begin
                Rst_n = 1'b0;
                #1;
                modelReset();
                checkAll();
                @(posedge Clk);
                modelStep();
                #1 checkAll();
                @(negedge Clk);
                Rst_n = 1'b1;
                applyStimulus();
            end
            @(posedge Clk);
            modelStep();
            #1 checkAll();
            @(negedge Clk);
        end

        checkOutput("burst_activity", grants_seen > 20, 1'b1);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
